// File: rtl/sram_like_if.sv
// CPU-side SRAM-like data bus: req/addr_ok request handshake plus data_ok response strobe.
// The err signal only exists when SRAM_RESP_ERR_EN is defined.
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
`ifdef SRAM_RESP_ERR_EN
    logic        err;

    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata, err);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata, err);
`else
    modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
`endif
endinterface

// File: rtl/sram_like_responder.sv
// Single-outstanding SRAM-like memory responder with a fixed response latency.
// Optional macro SRAM_RESP_ERR_EN adds an err response for misaligned requests.
module sram_like_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       rst,
    sram_like_if.slave bus,
    output logic [1:0] o_dbg_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Handshake: a request is taken on any rising edge where req && addr_ok;
    // data_ok then pulses for exactly one cycle, LATENCY cycles after that edge.
    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic            r_wr;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [0:DEPTH-1];

    logic            w_accept;
    logic            w_enter_resp;
    logic [AW-1:0]   w_sel_addr;
    logic [3:0]      w_be;
    logic            w_mem_we;
    logic            w_unused;

    assign w_unused     = ^bus.addr[31:AW];
    assign w_accept     = (r_state == S_IDLE) && bus.req;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    // When LATENCY==1 the response is loaded straight from the live bus fields.
    assign w_sel_addr   = (r_state == S_IDLE) ? bus.addr[AW-1:0] : r_addr;

`ifdef SRAM_RESP_ERR_EN
    logic       r_err;
    logic [1:0] w_sel_size;
    logic       w_sel_mis;

    assign w_sel_size = (r_state == S_IDLE) ? bus.size : r_size;
    assign w_sel_mis  = (w_sel_size == 2'd3) ||
                        ((w_sel_size == 2'd1) && w_sel_addr[0]) ||
                        ((w_sel_size == 2'd2) && (w_sel_addr[1:0] != 2'd0));
    assign w_mem_we   = (r_state == S_RESP) && r_wr && !r_err;
`else
    assign w_mem_we   = (r_state == S_RESP) && r_wr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.req) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt <= 4'd1) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.addr_ok = (r_state == S_IDLE);
        bus.data_ok = (r_state == S_RESP);
        bus.rdata   = r_rdata;
        o_dbg_state = r_state;
`ifdef SRAM_RESP_ERR_EN
        bus.err     = r_err;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
`ifdef SRAM_RESP_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_wr    <= bus.wr;
                r_size  <= bus.size;
                r_addr  <= bus.addr[AW-1:0];
                r_wdata <= bus.wdata;
                r_cnt   <= 4'(LATENCY - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
`ifdef SRAM_RESP_ERR_EN
                r_rdata <= w_sel_mis ? 32'd0 : r_mem[w_sel_addr[AW-1:2]];
                r_err   <= w_sel_mis;
`else
                r_rdata <= r_mem[w_sel_addr[AW-1:2]];
`endif
            end
        end
    end

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_addr[1:0];
            2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Store lands on the edge that ends RESP, so a read accepted next sees it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) r_mem[r_addr[AW-1:2]][8*k +: 8] <= r_wdata[8*k +: 8];
            end
        end
    end
endmodule
